// File: rtl/yc_pkg.sv
// Shared types and constants for the YC encoder configuration sequencer.
package yc_pkg;

  localparam logic [22:0] FSC_NTSC_HZ = 23'd3579545;
  localparam logic [22:0] FSC_PAL_HZ  = 23'd4433619;
  localparam int          DIV_ITERS   = 40;

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, PENDING, APPLY} yc_state_e;

  typedef struct packed {
    logic        pal;
    logic [31:0] clk_hz;
    logic [6:0]  cb_start;
    logic [9:0]  cb_end;
    logic        immediate;
  } yc_cfg_t;

  // COLORBURST_RANGE layout: {start, NTSC end, PAL end}
  localparam int CB_START_MSB = 26;
  localparam int CB_START_LSB = 20;
  localparam int CB_NTSC_MSB  = 19;
  localparam int CB_NTSC_LSB  = 10;
  localparam int CB_PAL_MSB   = 9;
  localparam int CB_PAL_LSB   = 0;

  function automatic logic [22:0] fsc_hz(input logic pal);
    return pal ? FSC_PAL_HZ : FSC_NTSC_HZ;
  endfunction

endpackage

// File: rtl/yc_cfg_ctrl_if.sv
// Request channel into the configuration sequencer (valid/ready, payload latched on transfer).
interface yc_cfg_ctrl_if;
  import yc_pkg::*;

  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_pal;
  logic [31:0] cfg_clk_hz;
  logic [6:0]  cfg_cb_start;
  logic [9:0]  cfg_cb_end;
  logic        cfg_immediate;

  modport master (
    output cfg_valid, cfg_pal, cfg_clk_hz, cfg_cb_start, cfg_cb_end, cfg_immediate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pal, cfg_clk_hz, cfg_cb_start, cfg_cb_end, cfg_immediate,
    output cfg_ready
  );

endinterface

// File: rtl/yc_phase_div.sv
// Serial restoring divider: quotient = floor(dividend * 2^40 / divisor), one bit per cycle.
// done is high during the 40th iteration; quotient is final from the following cycle.
module yc_phase_div
  import yc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [22:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [39:0] quotient
);

  logic [31:0] rem_q, rem_d;
  logic [39:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem2;
  logic [31:0] diff;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    rem2  = {rem_q, 1'b0};
    // rem < divisor holds throughout, so the true difference always fits 32 bits
    diff  = rem2[31:0] - divisor;
    if (start) begin
      rem_d = {9'd0, dividend};
      quo_d = '0;
      cnt_d = 6'(DIV_ITERS);
    end else if (cnt_q != 6'd0) begin
      if (rem2 >= {1'b0, divisor}) begin
        rem_d = diff;
        quo_d = {quo_q[38:0], 1'b1};
      end else begin
        rem_d = rem2[31:0];
        quo_d = {quo_q[38:0], 1'b0};
      end
      cnt_d = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign done     = (cnt_q == 6'd1);
  assign quotient = quo_q;

endmodule

// File: rtl/yc_cfg_ctrl.sv
// Validates a video-standard request, computes the subcarrier phase increment and
// applies PHASE_INC/PAL_EN/COLORBURST_RANGE together on a vsync rising edge (or at once).
module yc_cfg_ctrl
  import yc_pkg::*;
#(
  parameter logic [39:0] PHASE_INC_RST = 40'd183251937962,
  parameter logic [26:0] CB_RANGE_RST  = {7'd40, 10'd240, 10'd240},
  parameter logic        PAL_EN_RST    = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  yc_cfg_ctrl_if.slave   cfg,
  input  logic           vsync,
  output logic [39:0]    PHASE_INC,
  output logic           PAL_EN,
  output logic [26:0]    COLORBURST_RANGE,
  output logic           busy,
  output logic           applied,
  output logic           err
);

  yc_state_e   state_q, state_d;
  yc_cfg_t     cfg_q, cfg_d;
  logic        vs_d_q;
  logic [39:0] phase_inc_q, phase_inc_d;
  logic        pal_en_q, pal_en_d;
  logic [26:0] cb_range_q, cb_range_d;
  logic        applied_q, applied_d;
  logic        err_q, err_d;

  logic [22:0] fsc;
  logic        clk_ok, cb_ok, vs_edge, div_start, div_done;
  logic [39:0] div_quo;

  assign fsc       = fsc_hz(cfg_q.pal);
  assign clk_ok    = {1'b0, cfg_q.clk_hz} >= ({10'd0, fsc} << 1);
  assign cb_ok     = {3'd0, cfg_q.cb_start} <= cfg_q.cb_end;
  assign vs_edge   = vsync && !vs_d_q;
  assign div_start = (state_q == CHECK) && clk_ok && cb_ok;

  yc_phase_div u_div (
    .clk      (clk),
    .rst_n    (reset_n),
    .start    (div_start),
    .dividend (fsc),
    .divisor  (cfg_q.clk_hz),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    phase_inc_d = phase_inc_q;
    pal_en_d    = pal_en_q;
    cb_range_d  = cb_range_q;
    applied_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_valid) begin
          cfg_d = '{pal:       cfg.cfg_pal,
                    clk_hz:    cfg.cfg_clk_hz,
                    cb_start:  cfg.cfg_cb_start,
                    cb_end:    cfg.cfg_cb_end,
                    immediate: cfg.cfg_immediate};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (clk_ok && cb_ok) begin
          state_d = DIVIDE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        if (div_done) state_d = PENDING;
      end
      PENDING: begin
        // Everything lands on one edge so the encoder never sees a mixed configuration
        if (cfg_q.immediate || vs_edge) begin
          phase_inc_d = div_quo;
          pal_en_d    = cfg_q.pal;
          cb_range_d[CB_START_MSB:CB_START_LSB] = cfg_q.cb_start;
          if (cfg_q.pal) cb_range_d[CB_PAL_MSB:CB_PAL_LSB]   = cfg_q.cb_end;
          else           cb_range_d[CB_NTSC_MSB:CB_NTSC_LSB] = cfg_q.cb_end;
          applied_d = 1'b1;
          state_d   = APPLY;
        end
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      vs_d_q      <= 1'b0;
      phase_inc_q <= PHASE_INC_RST;
      pal_en_q    <= PAL_EN_RST;
      cb_range_q  <= CB_RANGE_RST;
      applied_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      vs_d_q      <= vsync;
      phase_inc_q <= phase_inc_d;
      pal_en_q    <= pal_en_d;
      cb_range_q  <= cb_range_d;
      applied_q   <= applied_d;
      err_q       <= err_d;
    end
  end

  assign cfg.cfg_ready     = (state_q == IDLE);
  assign busy              = (state_q != IDLE);
  assign PHASE_INC         = phase_inc_q;
  assign PAL_EN            = pal_en_q;
  assign COLORBURST_RANGE  = cb_range_q;
  assign applied           = applied_q;
  assign err               = err_q;

endmodule
